// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer_sequencer block.
// Contents:
//   ST_*_ENC : raw two-bit state encodings.
//   state_t  : controller state type built from those encodings.
package timer_seq_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_RUN  = ST_RUN_ENC,
    S_DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/mod_k_period_counter.sv
// Mod-k period counter. It counts 0..k-1 while enabled and wraps back to 0.
// A synchronous clear takes priority over counting.
// Ports:
//   i_clk, i_reset : clock and asynchronous active-high reset.
//   i_en           : advance the count this cycle.
//   i_clr          : force the count to 0 at the next edge.
//   i_k            : period k. The caller must screen out k==0.
//   o_count        : current count.
//   o_wrap         : count equals k-1, so the next enabled edge wraps.
module mod_k_period_counter #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [N-1:0] i_k,
  output logic [N-1:0] o_count,
  output logic         o_wrap
);

  logic [N-1:0] count_d, count_q;
  logic [N-1:0] k_m1;

  // k is never 0 while counting, so k-1 stays in range.
  assign k_m1    = i_k - N'(1);
  assign o_wrap  = (count_q == k_m1);
  assign o_count = count_q;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = o_wrap ? '0 : count_q + N'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Job controller for a mod-k period counter. It accepts (k, reps) over a
// valid/ready handshake and runs exactly reps full periods of k cycles. It
// strobes o_tick on every wrap and pulses o_done once when the job ends.
// A running job can be aborted.
// Ports:
//   i_clk, i_reset           : clock and asynchronous active-high reset.
//   i_cfg_valid, o_cfg_ready : job handshake. Ready is high only in IDLE.
//   i_cfg_k, i_cfg_reps      : period and repeat count, latched on handshake.
//   i_abort                  : terminate a running job and return to IDLE.
//   o_busy                   : job running.
//   o_count, o_rep           : position in the period, completed periods.
//   o_tick, o_done           : wrap strobe, one-cycle job-complete pulse.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cfg_valid,
  output logic         o_cfg_ready,
  input  logic [N-1:0] i_cfg_k,
  input  logic [R-1:0] i_cfg_reps,
  input  logic         i_abort,
  output logic         o_busy,
  output logic [N-1:0] o_count,
  output logic [R-1:0] o_rep,
  output logic         o_tick,
  output logic         o_done
);

  state_t       state_d, state_q;
  logic [N-1:0] k_d, k_q;
  logic [R-1:0] reps_d, reps_q;
  logic [R-1:0] rep_d, rep_q;
  logic         hs, run, wrap, cnt_clr;

  assign hs      = i_cfg_valid && (state_q == S_IDLE);
  assign run     = (state_q == S_RUN);
  assign cnt_clr = hs || (run && i_abort);

  mod_k_period_counter #(.N(N)) u_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (run),
    .i_clr   (cnt_clr),
    .i_k     (k_q),
    .o_count (o_count),
    .o_wrap  (wrap)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    reps_d  = reps_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          k_d    = i_cfg_k;
          reps_d = i_cfg_reps;
          rep_d  = '0;
          // A zero-length job goes straight to DONE without any ticks.
          state_d = (i_cfg_k == '0 || i_cfg_reps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
          rep_d   = '0;
        end else if (wrap) begin
          rep_d = rep_q + R'(1);
          if (rep_q == reps_q - R'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
    end
  end

  assign o_cfg_ready = (state_q == S_IDLE);
  assign o_busy      = run;
  assign o_rep       = rep_q;
  // Abort wins over a wrap in the same cycle, so the tick is suppressed.
  assign o_tick      = run && wrap && !i_abort;
  assign o_done      = (state_q == S_DONE);

endmodule
